// File: rtl/cpu_control_unit_pkg.sv
// Shared encodings for the hardwired CPU control sequencer.
// The WAIT state exists only when CU_SINGLE_STEP_EN is defined.
package cu_pkg;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        FETCH_L = 3'd1,
        FETCH_H = 3'd2,
        DECODE  = 3'd3,
        EXEC1   = 3'd4,
        EXEC2   = 3'd5,
        HALT    = 3'd6
`ifdef CU_SINGLE_STEP_EN
        ,
        WAIT    = 3'd7
`endif
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LDM = 4'h2;
    localparam logic [3:0] OP_STM = 4'h3;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_BRA = 4'hD;
    localparam logic [3:0] OP_BEQ = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] FUN_CLR  = 2'b00;
    localparam logic [1:0] FUN_LOAD = 2'b01;
    localparam logic [1:0] FUN_DEC  = 2'b10;
    localparam logic [1:0] FUN_INC  = 2'b11;

    localparam logic [3:0] ALU_PASS = 4'b0000;
    localparam logic [3:0] ALU_NOT  = 4'b0010;

    localparam logic [1:0] MUX_ALU = 2'd0;
    localparam logic [1:0] MUX_MEM = 2'd1;
    localparam logic [1:0] MUX_IR  = 2'd2;
    localparam logic [1:0] MUX_ARF = 2'd3;
    localparam logic       MUXC_RF  = 1'b0;
    localparam logic       MUXC_ARF = 1'b1;

    localparam logic [3:0] ARF_AR  = 4'b1000;
    localparam logic [3:0] ARF_SP  = 4'b0100;
    localparam logic [3:0] ARF_PCP = 4'b0010;
    localparam logic [3:0] ARF_PC  = 4'b0001;
    localparam logic [3:0] ARF_ALL = 4'b1111;
    localparam logic [1:0] ARF_RD_AR = 2'd0;
    localparam logic [1:0] ARF_RD_PC = 2'd3;
    localparam logic [3:0] RF_ALL    = 4'b1111;

    typedef struct packed {
        logic [1:0] outasel;
        logic [1:0] outbsel;
        logic [1:0] funsel_ir;
        logic [1:0] funsel_arf;
        logic [1:0] funsel_rf;
        logic [3:0] funsel_alu;
        logic [3:0] regsel_rf;
        logic [3:0] regsel_arf;
        logic [3:0] rf_tsel;
        logic [2:0] rf_o1sel;
        logic [2:0] rf_o2sel;
        logic       wr_mem;
        logic       cs_mem;
        logic       ir_enable;
        logic       ir_lh;
        logic [1:0] mux_sel_a;
        logic [1:0] mux_sel_b;
        logic       mux_sel_c;
    } ctrl_word_t;

    // Memory deselected (chip select is active-low) and every register holds.
    localparam ctrl_word_t CTRL_IDLE = '{
        outasel:    2'd0,
        outbsel:    2'd0,
        funsel_ir:  FUN_LOAD,
        funsel_arf: FUN_LOAD,
        funsel_rf:  FUN_LOAD,
        funsel_alu: ALU_PASS,
        regsel_rf:  4'b0000,
        regsel_arf: 4'b0000,
        rf_tsel:    4'b0000,
        rf_o1sel:   3'd0,
        rf_o2sel:   3'd0,
        wr_mem:     1'b0,
        cs_mem:     1'b1,
        ir_enable:  1'b0,
        ir_lh:      1'b0,
        mux_sel_a:  MUX_ALU,
        mux_sel_b:  MUX_ALU,
        mux_sel_c:  MUXC_RF
    };

    function automatic logic [2:0] rf_read_sel(input logic [1:0] d);
        return {1'b1, d};
    endfunction

    function automatic logic [3:0] rf_enable(input logic [1:0] d);
        return 4'b1000 >> d;
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= 4'h4) && (op <= 4'hC);
    endfunction

    function automatic logic is_binary_alu(input logic [3:0] op);
        return is_alu_op(op) && (op != OP_NOT) && (op != 4'hB) && (op != 4'hC);
    endfunction

    function automatic logic is_two_cycle(input logic [3:0] op);
        return (op == OP_LDM) || (op == OP_STM) || is_alu_op(op);
    endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// Control/status bundle between the sequencer (master) and the datapath (slave).
interface cpu_control_unit_if;
    logic [7:0] ir_msb;
    logic [3:0] alu_flag;
    logic [1:0] outasel;
    logic [1:0] outbsel;
    logic [1:0] funsel_IR;
    logic [1:0] funsel_arf;
    logic [1:0] funsel_rf;
    logic [3:0] funsel_alu;
    logic [3:0] regsel_rf;
    logic [3:0] regsel_arf;
    logic [3:0] rf_tsel;
    logic [2:0] rf_o1sel;
    logic [2:0] rf_o2sel;
    logic       wrMEM;
    logic       csMEM;
    logic       IR_enable;
    logic       IR_lh;
    logic [1:0] MUXSelA;
    logic [1:0] MUXSelB;
    logic       MUXSelC;

    modport master (
        input  ir_msb, alu_flag,
        output outasel, outbsel, funsel_IR, funsel_arf, funsel_rf, funsel_alu,
               regsel_rf, regsel_arf, rf_tsel, rf_o1sel, rf_o2sel,
               wrMEM, csMEM, IR_enable, IR_lh, MUXSelA, MUXSelB, MUXSelC
    );

    modport slave (
        output ir_msb, alu_flag,
        input  outasel, outbsel, funsel_IR, funsel_arf, funsel_rf, funsel_alu,
               regsel_rf, regsel_arf, rf_tsel, rf_o1sel, rf_o2sel,
               wrMEM, csMEM, IR_enable, IR_lh, MUXSelA, MUXSelB, MUXSelC
    );
endinterface

// File: rtl/cpu_control_unit_decoder.sv
// Moore control-word decoder: state + latched instruction + Z flag -> datapath controls.
module cu_decoder
    import cu_pkg::*;
(
    input  state_t     state,
    input  logic [7:0] instr,
    input  logic       zero_flag,
    output ctrl_word_t ctrl
);

    logic [3:0] opcode;
    logic [1:0] dst;
    logic [1:0] src;

    assign opcode = instr[7:4];
    assign dst    = instr[3:2];
    assign src    = instr[1:0];

    // Unary ALU ops feed their single operand through port A from src.
    function automatic ctrl_word_t alu_operands(input ctrl_word_t base);
        ctrl_word_t w;
        w = base;
        w.mux_sel_c  = MUXC_RF;
        w.funsel_alu = (opcode == OP_NOT) ? ALU_NOT : opcode;
        if (is_binary_alu(opcode)) begin
            w.rf_o1sel = rf_read_sel(dst);
            w.rf_o2sel = rf_read_sel(src);
        end else begin
            w.rf_o1sel = rf_read_sel(src);
        end
        return w;
    endfunction

    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            INIT: begin
                ctrl.regsel_arf = ARF_ALL;
                ctrl.regsel_rf  = RF_ALL;
                ctrl.rf_tsel    = RF_ALL;
                ctrl.funsel_arf = FUN_CLR;
                ctrl.funsel_rf  = FUN_CLR;
                ctrl.ir_enable  = 1'b1;
                ctrl.funsel_ir  = FUN_CLR;
            end
            FETCH_L, FETCH_H: begin
                ctrl.outbsel    = ARF_RD_PC;
                ctrl.cs_mem     = 1'b0;
                ctrl.ir_enable  = 1'b1;
                ctrl.funsel_ir  = FUN_LOAD;
                ctrl.ir_lh      = (state == FETCH_H);
                ctrl.regsel_arf = ARF_PC;
                ctrl.funsel_arf = FUN_INC;
            end
            EXEC1: begin
                case (opcode)
                    OP_LDI: begin
                        ctrl.mux_sel_a = MUX_IR;
                        ctrl.regsel_rf = rf_enable(dst);
                        ctrl.funsel_rf = FUN_LOAD;
                    end
                    OP_LDM: begin
                        ctrl.mux_sel_b  = MUX_IR;
                        ctrl.regsel_arf = ARF_AR;
                        ctrl.funsel_arf = FUN_LOAD;
                    end
                    OP_STM: begin
                        ctrl.mux_sel_b  = MUX_IR;
                        ctrl.regsel_arf = ARF_AR;
                        ctrl.funsel_arf = FUN_LOAD;
                        ctrl.mux_sel_c  = MUXC_RF;
                        ctrl.rf_o1sel   = rf_read_sel(src);
                        ctrl.funsel_alu = ALU_PASS;
                    end
                    OP_BRA, OP_BEQ: begin
                        ctrl.mux_sel_b  = MUX_IR;
                        ctrl.funsel_arf = FUN_LOAD;
                        ctrl.regsel_arf = (opcode == OP_BRA || zero_flag) ? ARF_PC : 4'b0000;
                    end
                    default: begin
                        if (is_alu_op(opcode)) begin
                            ctrl = alu_operands(ctrl);
                        end
                    end
                endcase
            end
            EXEC2: begin
                case (opcode)
                    OP_LDM: begin
                        ctrl.outbsel   = ARF_RD_AR;
                        ctrl.cs_mem    = 1'b0;
                        ctrl.mux_sel_a = MUX_MEM;
                        ctrl.regsel_rf = rf_enable(dst);
                        ctrl.funsel_rf = FUN_LOAD;
                    end
                    OP_STM: begin
                        ctrl.outbsel = ARF_RD_AR;
                        ctrl.cs_mem  = 1'b0;
                        ctrl.wr_mem  = 1'b1;
                    end
                    default: begin
                        if (is_alu_op(opcode)) begin
                            ctrl           = alu_operands(ctrl);
                            ctrl.mux_sel_a = MUX_ALU;
                            ctrl.regsel_rf = rf_enable(dst);
                            ctrl.funsel_rf = FUN_LOAD;
                        end
                    end
                endcase
            end
            default: ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit datapath; holds state and instruction registers.
// Optional single-step gating of instruction fetch with CU_SINGLE_STEP_EN.
module cpu_control_unit
    import cu_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
`ifdef CU_SINGLE_STEP_EN
    input  logic       step,
`endif
    cpu_control_unit_if.master bus,
    output logic       halted,
    output logic [2:0] state_dbg
);

    state_t     state_q;
    state_t     state_d;
    state_t     fetch_next;
    logic [7:0] instr_q;
    ctrl_word_t ctrl;

`ifdef CU_SINGLE_STEP_EN
    logic step_prev;
    logic step_latched;

    assign fetch_next = step_latched ? FETCH_L : WAIT;

    // A step edge is remembered until the fetch it authorises actually starts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step_prev    <= 1'b0;
            step_latched <= 1'b0;
        end else begin
            step_prev <= step;
            if (state_d == FETCH_L) begin
                step_latched <= 1'b0;
            end else if (step && !step_prev) begin
                step_latched <= 1'b1;
            end
        end
    end
`else
    assign fetch_next = FETCH_L;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
            instr_q <= 8'h00;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                instr_q <= bus.ir_msb;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = fetch_next;
            FETCH_L: state_d = FETCH_H;
            FETCH_H: state_d = DECODE;
            DECODE:  state_d = EXEC1;
            EXEC1: begin
                if (instr_q[7:4] == OP_HLT) begin
                    state_d = HALT;
                end else if (is_two_cycle(instr_q[7:4])) begin
                    state_d = EXEC2;
                end else begin
                    state_d = fetch_next;
                end
            end
            EXEC2:   state_d = fetch_next;
            HALT:    state_d = HALT;
`ifdef CU_SINGLE_STEP_EN
            WAIT:    state_d = step_latched ? FETCH_L : WAIT;
`endif
            default: state_d = INIT;
        endcase
    end

    cu_decoder u_decoder (
        .state     (state_q),
        .instr     (instr_q),
        .zero_flag (bus.alu_flag[3]),
        .ctrl      (ctrl)
    );

    assign bus.outasel    = ctrl.outasel;
    assign bus.outbsel    = ctrl.outbsel;
    assign bus.funsel_IR  = ctrl.funsel_ir;
    assign bus.funsel_arf = ctrl.funsel_arf;
    assign bus.funsel_rf  = ctrl.funsel_rf;
    assign bus.funsel_alu = ctrl.funsel_alu;
    assign bus.regsel_rf  = ctrl.regsel_rf;
    assign bus.regsel_arf = ctrl.regsel_arf;
    assign bus.rf_tsel    = ctrl.rf_tsel;
    assign bus.rf_o1sel   = ctrl.rf_o1sel;
    assign bus.rf_o2sel   = ctrl.rf_o2sel;
    assign bus.wrMEM      = ctrl.wr_mem;
    assign bus.csMEM      = ctrl.cs_mem;
    assign bus.IR_enable  = ctrl.ir_enable;
    assign bus.IR_lh      = ctrl.ir_lh;
    assign bus.MUXSelA    = ctrl.mux_sel_a;
    assign bus.MUXSelB    = ctrl.mux_sel_b;
    assign bus.MUXSelC    = ctrl.mux_sel_c;

    assign halted    = (state_q == HALT);
    assign state_dbg = state_q;

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Hardwired control sequencer that drives every control input of the 8-bit datapath top (`system`): ARF, RF, IR, memory, muxes A/B/C and ALU.
- It reads back `IR_out_MSBs` and the ALU flags, and runs a fetch/decode/execute loop.
- The datapath has no reset, so the controller also initialises the datapath registers.

Parameters:
- None. All encodings are fixed constants in the package.

Ports:
- `clock` in 1: system clock, rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `ir_msb` in 8: IR[15:8]. opcode=[7:4], dst=[3:2], src=[1:0].
- `alu_flag` in 4: ALU flags. [3]=Z, [2]=C, [1]=N, [0]=V.
- `outasel`, `outbsel` out 2 each: ARF read selects.
- `funsel_IR`, `funsel_arf`, `funsel_rf` out 2 each: register function selects.
- `funsel_alu` out 4: ALU function select.
- `regsel_rf`, `regsel_arf`, `rf_tsel` out 4 each: one-hot register enables.
- `rf_o1sel`, `rf_o2sel` out 3 each: RF read selects.
- `wrMEM`, `csMEM` out 1 each: memory write strobe and chip select (chip select active-low).
- `IR_enable`, `IR_lh` out 1 each: IR load enable and byte select.
- `MUXSelA`, `MUXSelB` out 2 each; `MUXSelC` out 1: datapath mux selects.
- `halted` out 1: high in HALT.
- `state_dbg` out 3: current state code.

Behaviour:
- Encodings:
  - funsel: 00 clear, 01 load, 10 dec, 11 inc.
  - ARF one-hot: AR=1000, SP=0100, PCP=0010, PC=0001. ARF read select: AR=0, PC=3.
  - RF register d (0..3 = R1..R4): read select = 4+d, enable = 1000>>d.
  - MUXSelA/B: 0 ALU, 1 MEM, 2 IR[7:0], 3 ARF outa.
  - MUXSelC: 0 rf_o1, 1 ARF outa.
- Idle word: every enable 0, `rf_tsel`=0000, `IR_enable`=0, `csMEM`=1, `wrMEM`=0, all funsel 01, `funsel_alu`=0000, all mux/read selects 0. Any field a state does not name takes its idle value.
- Outputs are Moore, decoded combinationally from the state register and the instr register (8 bits).
- Reset: state=INIT, instr=00, `halted`=0, `state_dbg`=0; outputs show the INIT word. Reset asserted mid-instruction aborts it immediately; no partial memory write continues after the reset edge.
- States (codes): INIT 0, FETCH_L 1, FETCH_H 2, DECODE 3, EXEC1 4, EXEC2 5, HALT 6.
- INIT: `regsel_arf`=1111, `regsel_rf`=1111, `rf_tsel`=1111, `funsel_arf`=`funsel_rf`=00, `IR_enable`=1, `funsel_IR`=00. Next FETCH_L.
- FETCH_L: `outbsel`=3, `csMEM`=0, `IR_enable`=1, `funsel_IR`=01, `IR_lh`=0, PC inc (`regsel_arf`=0001, `funsel_arf`=11). Next FETCH_H.
- FETCH_H: same as FETCH_L with `IR_lh`=1. Next DECODE.
- DECODE: instr<=`ir_msb`; outputs idle. Next EXEC1.
- 0x0 NOP: EXEC1 idle.
- 0x1 LDI: EXEC1 R[dst]<=IR[7:0] (`MUXSelA`=2, `funsel_rf`=01).
- 0x2 LDM:
  - EXEC1: AR<=IR[7:0] (`MUXSelB`=2, `funsel_arf`=01).
  - EXEC2: `outbsel`=0, `csMEM`=0, `MUXSelA`=1, load R[dst].
- 0x3 STM:
  - EXEC1: AR<=IR[7:0]; `MUXSelC`=0, `rf_o1sel`=R[src], `funsel_alu`=0000.
  - EXEC2: `outbsel`=0, `csMEM`=0, `wrMEM`=1.
- 0x4-0xC ALU ops, R[dst]<=result:
  - `funsel_alu`=opcode, except 0x6 which uses 0010 (NOT).
  - Binary ops (4,5,7,8,9,A): A=R[dst] via `rf_o1sel`, B=R[src] via `rf_o2sel`.
  - Unary ops (6,B,C): A=R[src].
  - EXEC1 drives `MUXSelC`=0 and the selects. EXEC2 holds them and adds `MUXSelA`=0 plus load R[dst]. The ALU output is registered, hence two cycles.
- 0xD BRA: EXEC1 PC<=IR[7:0] (`MUXSelB`=2, `regsel_arf`=0001, `funsel_arf`=01).
- 0xE BEQ: as BRA, but `regsel_arf`=0001 only if `alu_flag[3]`=1 (sampled in EXEC1); otherwise 0000.
- 0xF HLT: EXEC1 goes to HALT.
- Transitions after execute: one-cycle ops go EXEC1->FETCH_L; two-cycle ops go EXEC2->FETCH_L.
- HALT: idle word, `halted`=1, absorbing until reset.
- PC wraps FF->00 (datapath arithmetic); the controller imposes no bound.

Optional Feature:
- Macro `CU_SINGLE_STEP_EN`.
- Defined: adds input `step` (1 bit). Entry to FETCH_L requires a latched step pulse. Otherwise the controller waits in a WAIT state (code 7) driving the idle word. A rising `step` while waiting is latched and the wait is released on the next cycle.
- Undefined: no `step` port, no WAIT state; FETCH_L follows immediately.

Decomposition:
- Package `cu_pkg`: state enum, opcode constants, funsel codes, mux select codes, ARF/RF one-hot masks, idle control-word constant.
- Sub-module `cu_decoder` (combinational): state + instr + Z -> control word. The top holds the state register, instr register and step latch.

Test Plan:
- Reset low mid-EXEC2 of STM -> next cycle shows the INIT word with `wrMEM`=0. Then FETCH_L with `outbsel`=3, `csMEM`=0, `IR_lh`=0, `regsel_arf`=0001, `funsel_arf`=11.
- `ir_msb`=0x1C (LDI R4) -> EXEC1 `MUXSelA`=2, `regsel_rf`=0001, `funsel_rf`=01; FETCH_L again 4 cycles after the previous FETCH_L.
- `ir_msb`=0x46 (ADD R2,R3) -> EXEC1 `rf_o1sel`=5, `rf_o2sel`=6, `funsel_alu`=0100, `regsel_rf`=0000; EXEC2 `MUXSelA`=0, `regsel_rf`=0100.
- `ir_msb`=0x33 (STM R4) -> EXEC1 `rf_o1sel`=7, `MUXSelB`=2, `regsel_arf`=1000; EXEC2 `outbsel`=0, `csMEM`=0, `wrMEM`=1.
- `ir_msb`=0xE0 with `alu_flag`=1000 -> EXEC1 `regsel_arf`=0001, `MUXSelB`=2; with `alu_flag`=0000 -> `regsel_arf`=0000.
- `ir_msb`=0xF0 -> `halted`=1, `state_dbg`=6 and idle word for 20 cycles; with `CU_SINGLE_STEP_EN`, no `step` pulse -> `state_dbg` stays 7.
